// File: rtl/bitrev_frame_buffer.sv
// -----------------------------------------------------------------------------
// bitrev_frame_buffer
//
// Ping-pong frame buffer on the FFT input path. The block collects frames of
// N = 2**LOG2_N samples in natural order into one bank while the other bank
// is replayed in bit-reversed address order to the accumulation stage.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : upstream sample valid
//   in_ready   : buffer can accept a sample this cycle (registered state only)
//   in_data    : input sample, DATA_W bits, two's complement
//   out_valid  : out_data / out_last / out_index hold a valid word
//   out_ready  : downstream accepts the output word
//   out_data   : reordered sample
//   out_last   : high on the final word of a frame
//   out_index  : natural-order index of out_data within its frame
//
// Parameters
//   DATA_W     : sample width
//   LOG2_N     : log2 of the frame length
//
// Build option
//   BITREV_HALFSCALE_EN : when defined, out_data is the stored sample shifted
//                         right by one (sign preserving) to give the
//                         accumulation stage a bit of headroom.
// -----------------------------------------------------------------------------
module bitrev_frame_buffer #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [LOG2_N-1:0] out_index
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2_N; b++) begin
            r[b] = a[LOG2_N-1-b];
        end
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W-1:0] s);
`ifdef BITREV_HALFSCALE_EN
        return s >>> 1;
`else
        return s;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic signed [DATA_W-1:0] mem_q [2][N];

    logic [1:0]               full_q;
    logic [1:0]               full_d;
    logic                     wr_bank_q;
    logic                     rd_bank_q;
    logic [LOG2_N-1:0]        wr_cnt_q;
    logic [LOG2_N-1:0]        rd_cnt_q;
    state_t                   state_q;

    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     out_last_q;
    logic [LOG2_N-1:0]        out_index_q;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic                     wr_acc;
    logic                     wr_last;
    logic                     rd_load;
    logic                     rd_last;
    logic [LOG2_N-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_word;

    assign in_ready = !full_q[wr_bank_q];
    assign wr_acc   = in_valid && !full_q[wr_bank_q];
    assign wr_last  = wr_acc && (wr_cnt_q == CNT_LAST);

    // The output register is the only read stage; it refills whenever it is
    // empty or its current word is being taken this cycle.
    assign rd_load  = (state_q == STREAM) && (!out_valid_q || out_ready);
    assign rd_last  = rd_load && (rd_cnt_q == CNT_LAST);
    assign rd_addr  = bitrev(rd_cnt_q);
    assign rd_word  = mem_q[rd_bank_q][rd_addr];

    // The writer only ever completes a bank that is not full and the reader
    // only ever releases a bank that is full, so the two updates never target
    // the same flag and may both land on one edge.
    always_comb begin
        full_d = full_q;
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Sample storage (no reset: contents are don't-care until written)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_bank_q][wr_cnt_q] <= signed'(in_data);
        end
    end

    // -------------------------------------------------------------------------
    // Write pointer, bank flags, read state machine and output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
        end else begin
            full_q <= full_d;

            if (wr_acc) begin
                if (wr_last) begin
                    wr_bank_q <= !wr_bank_q;
                    wr_cnt_q  <= '0;
                end else begin
                    wr_cnt_q  <= wr_cnt_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    // A word left over from the previous frame may still be
                    // waiting for the downstream.
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (full_q[rd_bank_q]) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_load) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= scale(rd_word);
                        out_index_q <= rd_addr;
                        out_last_q  <= (rd_cnt_q == CNT_LAST);
                        if (rd_last) begin
                            rd_bank_q <= !rd_bank_q;
                            rd_cnt_q  <= '0;
                            // Look at the next-state flag so a frame that
                            // completes on this same edge follows without a
                            // gap in out_valid.
                            if (!full_d[!rd_bank_q]) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;

endmodule

// File: tb/tb_bitrev_frame_buffer.sv
module tb_bitrev_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic [3:0]  out_index;

    always #5 clk = ~clk;

    bitrev_frame_buffer #(.DATA_W(16), .LOG2_N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_index (out_index)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  i;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] got_d[$];
    logic [3:0]  got_i[$];
    logic [15:0] fbuf[16];
    int          fcnt;

    int total = 0;
    int bad   = 0;

    int cyc, n_acc, n_out, last_acc_edge, first_vld_edge;
    int stalls, early_stalls, run, max_run, ir_rise_out;
    logic ov_prev, ir_prev;

    // Natural order 0..15 seen through a 4-bit bit reversal.
    logic [3:0] rev_tab[16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    function automatic logic [15:0] exp_scale(input logic [15:0] s);
`ifdef BITREV_HALFSCALE_EN
        return {s[15], s[15:1]};
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_d.delete();
        got_i.delete();
        fcnt = 0; cyc = 0; n_acc = 0; n_out = 0;
        last_acc_edge = -1; first_vld_edge = -1;
        stalls = 0; early_stalls = 0; run = 0; max_run = 0; ir_rise_out = -1;
        ov_prev = 1'b0; ir_prev = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        rst_n = 1'b1;
    endtask

    // One clock: drive, sample handshakes, score what crossed the edge.
    task automatic cycle(input logic iv, input logic [15:0] id, input logic ordy);
        logic acc_i, acc_o, hold;
        logic [15:0] od;
        logic [3:0]  oi;
        logic        ol;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        acc_i = in_valid && in_ready;
        acc_o = out_valid && out_ready;
        hold  = out_valid && !out_ready;
        if (in_valid && !in_ready) begin
            stalls++;
            if (n_acc < 32) early_stalls++;
        end
        od = out_data; oi = out_index; ol = out_last;
        @(posedge clk);
        cyc++;
        if (acc_i) begin
            fbuf[fcnt] = id;
            fcnt++;
            n_acc++;
            last_acc_edge = cyc;
            if (fcnt == 16) begin
                for (int k = 0; k < 16; k++) begin
                    exp_q.push_back('{d: exp_scale(fbuf[rev_tab[k]]), i: rev_tab[k], l: (k == 15)});
                end
                fcnt = 0;
            end
        end
        if (acc_o) begin
            got_d.push_back(od);
            got_i.push_back(oi);
            n_out++;
            if (exp_q.size() == 0) begin
                chk("extra_word", 32'(od), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data",  32'(od), 32'(e.d));
                chk("sb_index", 32'(oi), 32'(e.i));
                chk("sb_last",  32'(ol), 32'(e.l));
            end
        end
        #1;
        if (hold) begin
            chk("hold_data",  32'(out_data),  32'(od));
            chk("hold_index", 32'(out_index), 32'(oi));
            chk("hold_last",  32'(out_last),  32'(ol));
        end
        if (out_valid && !ov_prev && first_vld_edge < 0) first_vld_edge = cyc;
        if (out_valid) run++; else run = 0;
        if (run > max_run) max_run = run;
        if (in_ready && !ir_prev && ir_rise_out < 0) ir_rise_out = n_out;
        ov_prev = out_valid;
        ir_prev = in_ready;
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);

        // 1: single frame, natural-order ramp
        do_reset();
        for (int k = 0; k < 16; k++) cycle(1'b1, 16'(k), 1'b1);
        for (int k = 0; k < 22; k++) cycle(1'b0, 16'h0, 1'b1);
        chk("t1_count", 32'(n_out), 32'd16);
        chk("t1_latency", 32'(first_vld_edge - last_acc_edge), 32'd2);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 16 && k < got_d.size(); k++) begin
            chk("t1_order_data",  32'(got_d[k]), 32'(rev_tab[k]));
            chk("t1_order_index", 32'(got_i[k]), 32'(rev_tab[k]));
        end

        // 2: three frames back to back. The first two frames see no stall;
        // frame 3 targets the bank that frame 1 releases on the edge loading
        // its last word, so it can wait at most one cycle.
        do_reset();
        for (int k = 0; k < 100 && n_acc < 48; k++) cycle(1'b1, 16'(1000 + n_acc), 1'b1);
        for (int k = 0; k < 25; k++) cycle(1'b0, 16'h0, 1'b1);
        chk("t2_accepted", 32'(n_acc), 32'd48);
        chk("t2_early_stall", 32'(early_stalls), 32'd0);
        chk("t2_stall_bound", 32'(stalls <= 1), 32'd1);
        chk("t2_gapless_run", 32'(max_run), 32'd48);
        chk("t2_count", 32'(n_out), 32'd48);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: downstream stalled, both banks fill, then drain
        do_reset();
        for (int k = 0; k < 40; k++) cycle(1'b1, 16'(k), 1'b0);
        chk("t3_accepted", 32'(n_acc), 32'd32);
        chk("t3_in_ready_low", 32'(in_ready), 32'd0);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_held_data", 32'(out_data), 32'd0);
        chk("t3_held_index", 32'(out_index), 32'd0);
        ir_rise_out = -1;
        for (int k = 0; k < 100 && n_out < 32; k++) cycle(1'b0, 16'h0, 1'b1);
        chk("t3_drained", 32'(n_out), 32'd32);
        chk("t3_ready_after_frame1", 32'(ir_rise_out), 32'd15);
        chk("t3_in_ready_end", 32'(in_ready), 32'd1);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: reset in the middle of a frame
        do_reset();
        for (int k = 0; k < 7; k++) cycle(1'b1, 16'(500 + k), 1'b1);
        do_reset();
        for (int k = 0; k < 16; k++) cycle(1'b1, 16'(16'h100 + k), 1'b1);
        for (int k = 0; k < 25; k++) cycle(1'b0, 16'h0, 1'b1);
        chk("t4_count", 32'(n_out), 32'd16);
        if (got_i.size() > 0) chk("t4_first_index", 32'(got_i[0]), 32'd0);
        else chk("t4_first_index", 32'hFFFF, 32'd0);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: full-scale extremes
        do_reset();
        cycle(1'b1, 16'h8000, 1'b1);
        cycle(1'b1, 16'h7FFF, 1'b1);
        for (int k = 2; k < 16; k++) cycle(1'b1, 16'(k), 1'b1);
        for (int k = 0; k < 22; k++) cycle(1'b0, 16'h0, 1'b1);
        chk("t5_count", 32'(n_out), 32'd16);
`ifdef BITREV_HALFSCALE_EN
        if (got_d.size() > 8) begin
            chk("t5_word1", 32'(got_d[0]), 32'hC000);
            chk("t5_word9", 32'(got_d[8]), 32'h3FFF);
        end
`else
        if (got_d.size() > 8) begin
            chk("t5_word1", 32'(got_d[0]), 32'h8000);
            chk("t5_word9", 32'(got_d[8]), 32'h7FFF);
        end
`endif

        // 6: random bubbles and stalls over ten frames
        do_reset();
        for (int k = 0; k < 4000 && n_acc < 160; k++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 200 && exp_q.size() > 0; k++)
            cycle(1'b0, 16'h0, 1'($urandom_range(0, 3) != 0));
        repeat (3) cycle(1'b0, 16'h0, 1'b1);
        chk("t6_accepted", 32'(n_acc), 32'd160);
        chk("t6_count", 32'(n_out), 32'd160);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_idle_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
